// File: rtl/seg7_pkg.sv
// seg7_pkg: common-anode glyph table, blank pattern and digit-index width helper
package seg7_pkg;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [15:0][6:0] GLYPH = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph: nibble to active-low {g..a}; decimal mode blanks 10-15
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] seg
);
  always_comb seg = (hex_mode || nibble < 4'd10) ? GLYPH[nibble] : SEG_OFF;
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode 7-segment scanner with frame-synchronous shadow load.
// Define SEG7_LZ_BLANK_EN to blank zero digits above the most significant nonzero digit.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_mode,
  input  logic                    blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);
  localparam int IW = idx_width(NUM_DIGITS);
  localparam int CW = $clog2(SCAN_DIV);
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    hex;
  } disp_t;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  disp_t shadow_q, shadow_d, disp_q, disp_d;
  logic pending_q, pending_d, frame_tick_q, frame_tick_d, dp_q, dp_d;
  logic [6:0] seg_q, seg_d, glyph_seg;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0] nibble;
  logic slot_tick, wrap;
  seg7_glyph u_glyph (.nibble(nibble), .hex_mode(disp_q.hex), .seg(glyph_seg));
  always_comb begin
    slot_tick    = cnt_q == CW'(SCAN_DIV - 1);
    wrap         = slot_tick && idx_q == IW'(NUM_DIGITS - 1);
    cnt_d        = slot_tick ? '0 : cnt_q + 1'b1;
    idx_d        = wrap ? '0 : slot_tick ? idx_q + 1'b1 : idx_q;
    shadow_d     = load ? {value, dp_in, hex_mode} : shadow_q;
    // a load landing on the wrap edge stays pending for the following frame
    pending_d    = load | (pending_q & ~wrap);
    disp_d       = (wrap && pending_q) ? shadow_q : disp_q;
    frame_tick_d = wrap;
    nibble       = 4'(disp_q.value >> (4 * idx_q));
    an_d         = blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    dp_d         = blank | ~disp_q.dp[idx_q];
`ifdef SEG7_LZ_BLANK_EN
    seg_d        = (blank || (idx_q != '0 && (disp_q.value >> (4 * idx_q)) == '0)) ? SEG_OFF : glyph_seg;
`else
    seg_d        = blank ? SEG_OFF : glyph_seg;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      an_q         <= '1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;
endmodule
